// File: rtl/wait_state_mem.sv
// ============================================================================
// Module   : wait_state_mem
// Purpose  : Unified instruction/data memory with configurable wait states.
//            A request is accepted in IDLE or DONE, waits LATENCY cycles,
//            then completes with a one-cycle ready pulse. Writes use byte
//            enables. Misaligned or out-of-range accesses complete with err=1,
//            leave the array untouched and return rdata=0.
// Ports    : clk, rst            clock, synchronous active-high reset
//            req, we, addr,      request and its operands, captured on accept
//            wdata, be
//            rdata               read data, registered, held between reads
//            ready               one-cycle completion pulse
//            busy                transaction outstanding and not yet ready
//            err                 error flag, valid with ready
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module wait_state_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 1024,
  parameter int LATENCY    = 2,
  parameter     INIT_FILE  = ""
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req,
  input  logic                    we,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] be,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    ready,
  output logic                    busy,
  output logic                    err
);

  localparam int NB  = DATA_WIDTH / 8;
  localparam int OFF = (NB > 1) ? $clog2(NB) : 0;
  localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW  = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;

  localparam logic [CW-1:0]       CNT_LOAD  = CW'((LATENCY > 0) ? LATENCY - 1 : 0);
  localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_n;
  logic [CW-1:0]         cnt;
  logic                  cap_we;
  logic [ADDR_WIDTH-1:0] cap_addr;
  logic [DATA_WIDTH-1:0] cap_wdata;
  logic [NB-1:0]         cap_be;
  logic                  err_q;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  accept;
  logic                  complete;
  logic                  op_we;
  logic [ADDR_WIDTH-1:0] op_addr;
  logic [DATA_WIDTH-1:0] op_wdata;
  logic [NB-1:0]         op_be;
  logic                  misalign;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic                  op_err;
  logic [IW-1:0]         mem_idx;

  assign accept = req && ((state == IDLE) || (state == DONE));

  // With zero latency the access completes on the accepting edge itself,
  // so the operands come straight from the inputs; otherwise from the
  // values captured when the request was accepted.
  generate
    if (LATENCY == 0) begin : g_lat_zero
      assign complete = accept;
      assign op_we    = we;
      assign op_addr  = addr;
      assign op_wdata = wdata;
      assign op_be    = be;
    end else begin : g_lat_wait
      assign complete = (state == WAIT) && (cnt == '0);
      assign op_we    = cap_we;
      assign op_addr  = cap_addr;
      assign op_wdata = cap_wdata;
      assign op_be    = cap_be;
    end
  endgenerate

  generate
    if (OFF > 0) begin : g_align_chk
      assign misalign = |op_addr[OFF-1:0];
    end else begin : g_align_none
      assign misalign = 1'b0;
    end
  endgenerate

  assign word_idx = op_addr >> OFF;
  assign op_err   = misalign || ({1'b0, word_idx} >= DEPTH_EXT);
  assign mem_idx  = word_idx[IW-1:0];

  always_comb begin
    state_n = state;
    case (state)
      IDLE, DONE: begin
        if (req) begin
          if (LATENCY > 0) state_n = WAIT;
          else             state_n = DONE;
        end else begin
          state_n = IDLE;
        end
      end
      WAIT: begin
        if (cnt == '0) state_n = DONE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      cap_we    <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
      cap_be    <= '0;
      rdata     <= '0;
      err_q     <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        cap_we    <= we;
        cap_addr  <= addr;
        cap_wdata <= wdata;
        cap_be    <= be;
        cnt       <= CNT_LOAD;
      end else if ((state == WAIT) && (cnt != '0)) begin
        cnt <= cnt - 1'b1;
      end
      if (complete) begin
        err_q <= op_err;
        if (op_err)      rdata <= '0;
        else if (!op_we) rdata <= mem[mem_idx];
      end
    end
  end

  // Array has no reset; reset only suppresses a write that would otherwise
  // land on the same edge, which is how an aborted write is discarded.
  always_ff @(posedge clk) begin
    if (!rst && complete && op_we && !op_err) begin
      for (int b = 0; b < NB; b++) begin
        if (op_be[b]) mem[mem_idx][8*b +: 8] <= op_wdata[8*b +: 8];
      end
    end
  end

  assign ready = (state == DONE);
  assign busy  = (state == WAIT);
  assign err   = (state == DONE) && err_q;

endmodule

`default_nettype wire

// File: tb/tb_wait_state_mem.sv
// ============================================================================
// Module   : tb_wait_state_mem
// Purpose  : Scoreboard bench for wait_state_mem. Two instances: LATENCY=2
//            and LATENCY=0, selected by 'sel'. A driver issues requests and
//            pushes the expected completion (cycle, rdata, err) computed from
//            a word-array model; a monitor pops and compares on every ready.
// Ports    : none
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_wait_state_mem;

  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  be = '0;
  logic        sel = 1'b0;   // 0: LATENCY=2 instance, 1: LATENCY=0 instance

  logic [31:0] rdata2, rdata0;
  logic        ready2, ready0, busy2, busy0, err2, err0;

  always #5 clk = ~clk;

  wait_state_mem #(.LATENCY(2)) u_dut2 (
    .clk(clk), .rst(rst), .req(req & ~sel), .we(we), .addr(addr),
    .wdata(wdata), .be(be), .rdata(rdata2), .ready(ready2), .busy(busy2), .err(err2)
  );

  wait_state_mem #(.LATENCY(0)) u_dut0 (
    .clk(clk), .rst(rst), .req(req & sel), .we(we), .addr(addr),
    .wdata(wdata), .be(be), .rdata(rdata0), .ready(ready0), .busy(busy0), .err(err0)
  );

  typedef struct {
    int          acc;
    logic [31:0] rd;
    logic        er;
  } exp_t;

  exp_t        q[$];
  logic [31:0] mdl [2][DEPTH];
  logic [31:0] mrd [2];
  int          cyc = 0;
  int          total = 0;
  int          passed = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lat();
    return sel ? 0 : 2;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Reference model: word array with byte merge, evaluated at accept time.
  task automatic issue(input bit w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] b);
    int   s;
    int   idx;
    logic e;
    exp_t x;
    s   = sel ? 1 : 0;
    idx = int'(a / 4);
    e   = (a % 4 != 0) || (a / 4 >= DEPTH);
    if (!e && w)
      for (int i = 0; i < 4; i++)
        if (b[i]) mdl[s][idx][8*i +: 8] = d[8*i +: 8];
    if (e)      x.rd = 32'h0;
    else if (w) x.rd = mrd[s];
    else        x.rd = mdl[s][idx];
    mrd[s] = x.rd;
    x.acc  = cyc;
    x.er   = e;
    q.push_back(x);
  endtask

  // Called just after a rising edge with the DUT able to accept at the next one.
  task automatic txn(input bit w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] b, input int gap, input bit junk);
    req = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    req = 1'b1; we = w; addr = a; wdata = d; be = b;
    @(posedge clk); #1;
    issue(w, a, d, b);
    req = 1'b0;
    for (int i = 0; i < lat(); i++) begin
      if (junk) begin
        req = 1'b1; we = 1'($urandom); addr = 32'h100 + 4 * $urandom_range(0, 15);
        wdata = $urandom; be = 4'($urandom);
      end
      @(posedge clk); #1;
    end
    req = 1'b0;
  endtask

  task automatic check_idle_outputs();
    chk("reset_ready", sel ? ready0 : ready2, 1'b0);
    chk("reset_busy",  sel ? busy0  : busy2,  1'b0);
    chk("reset_err",   sel ? err0   : err2,   1'b0);
    chk("reset_rdata", sel ? rdata0 : rdata2, 32'h0);
  endtask

  task automatic do_reset();
    req = 1'b0;
    rst = 1'b1;
    q.delete();
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    mrd[0] = 32'h0; mrd[1] = 32'h0;
    check_idle_outputs();
    repeat (4) begin @(posedge clk); #1; end
  endtask

  // Monitor: compares completions against the scoreboard and checks busy.
  always @(negedge clk) begin
    logic        r, bz, er;
    logic [31:0] rd;
    exp_t        e;
    if (!rst) begin
      r  = sel ? ready0 : ready2;
      bz = sel ? busy0  : busy2;
      er = sel ? err0   : err2;
      rd = sel ? rdata0 : rdata2;
      if (q.size() > 0 && cyc > q[0].acc + lat()) begin
        chk("ready_missing", 32'h0, 32'h1);
        void'(q.pop_front());
      end
      if (r) begin
        if (q.size() == 0) begin
          chk("spurious_ready", 32'h1, 32'h0);
        end else begin
          e = q.pop_front();
          chk("ready_cycle", cyc, e.acc + lat());
          chk("rdata", rd, e.rd);
          chk("err", er, e.er);
          chk("busy_with_ready", bz, 1'b0);
        end
      end else begin
        chk("busy", bz, (q.size() > 0) && (cyc < q[0].acc + lat()));
        chk("err_without_ready", er, 1'b0);
      end
    end
  end

  initial begin
    logic [31:0] a;
    int          r;
    #1;
    do_reset();

    // Write then read, busy two cycles, ready on the third.
    txn(1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 0);
    txn(0, 32'h10, 32'h0, 4'h0, 1, 0);
    // be=0 completes without changing the word.
    txn(1, 32'h10, 32'h12345678, 4'h0, 0, 0);
    txn(0, 32'h10, 32'h0, 4'h0, 0, 0);
    // Byte enables: expect 0x11BB33DD.
    txn(1, 32'h20, 32'h11223344, 4'hF, 0, 0);
    txn(1, 32'h20, 32'hAABBCCDD, 4'b0101, 0, 0);
    txn(0, 32'h20, 32'h0, 4'h0, 0, 0);
    // Errors: out of range read, misaligned write, then word 0x20 unchanged.
    txn(0, 32'h1000, 32'h0, 4'h0, 0, 0);
    txn(0, 32'h20, 32'h0, 4'h0, 0, 0);
    txn(1, 32'h22, 32'hFFFFFFFF, 4'hF, 0, 0);
    txn(0, 32'h20, 32'h0, 4'h0, 0, 0);
    txn(0, 32'hFFC, 32'h0, 4'h0, 0, 0);
    // req held during WAIT with other operands is ignored.
    txn(1, 32'h10, 32'h5A5AA5A5, 4'hF, 0, 1);
    txn(0, 32'h10, 32'h0, 4'h0, 0, 1);

    // Reset in the first WAIT cycle of a write.
    txn(1, 32'h30, 32'h01020304, 4'hF, 0, 0);
    txn(0, 32'h30, 32'h0, 4'h0, 0, 0);
    repeat (2) begin @(posedge clk); #1; end
    req = 1'b1; we = 1'b1; addr = 32'h30; wdata = 32'hCAFEF00D; be = 4'hF;
    @(posedge clk); #1;
    req = 1'b0;
    do_reset();
    txn(0, 32'h30, 32'h0, 4'h0, 0, 0);

    // Randomised traffic on the LATENCY=2 instance.
    for (int i = 0; i < 16; i++) txn(1, 32'h100 + 4 * i, $urandom, 4'hF, 0, 0);
    for (int i = 0; i < 120; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      a = 32'h100 + 4 * $urandom_range(0, 15) + $urandom_range(1, 3);
      else if (r == 1) a = 32'h1000 + 4 * $urandom_range(0, 4095);
      else             a = 32'h100 + 4 * $urandom_range(0, 15);
      txn(1'($urandom), a, $urandom, 4'($urandom), $urandom_range(0, 2), 1'($urandom));
    end
    repeat (4) begin @(posedge clk); #1; end

    // LATENCY=0 instance: back-to-back writes, then 4 back-to-back reads.
    sel = 1'b1;
    do_reset();
    for (int i = 0; i < 4; i++) txn(1, 32'h40 + 4 * i, 32'hA0000000 + i * 32'h01010101, 4'hF, 0, 0);
    repeat (2) begin @(posedge clk); #1; end
    for (int i = 0; i < 4; i++) txn(0, 32'h40 + 4 * i, 32'h0, 4'h0, 0, 0);
    txn(0, 32'h1000, 32'h0, 4'h0, 0, 0);
    txn(1, 32'h42, 32'h0, 4'hF, 0, 0);
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0) a = 32'h40 + 4 * $urandom_range(0, 3) + $urandom_range(1, 3);
      else        a = 32'h40 + 4 * $urandom_range(0, 3);
      txn(1'($urandom), a, $urandom, 4'($urandom), $urandom_range(0, 1), 0);
    end

    repeat (5) begin @(posedge clk); #1; end
    if (q.size() != 0) chk("drain", q.size(), 32'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
